// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host transmitter state encoding, common command bytes
// and the frame parity helper.
package ps2_pkg;

   localparam logic [2:0] ST_IDLE      = 3'd0;
   localparam logic [2:0] ST_INHIBIT   = 3'd1;
   localparam logic [2:0] ST_REQ       = 3'd2;
   localparam logic [2:0] ST_SEND      = 3'd3;
   localparam logic [2:0] ST_WAIT_IDLE = 3'd4;

   localparam logic [7:0] PS2_CMD_LED    = 8'hED;
   localparam logic [7:0] PS2_CMD_ENABLE = 8'hF4;
   localparam logic [7:0] PS2_CMD_RESET  = 8'hFF;
   localparam logic [7:0] PS2_ACK_BYTE   = 8'hFA;

   // PS/2 frames carry odd parity over the data byte.
   function automatic logic ps2_odd_parity(input logic [7:0] data);
      return ~^data;
   endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// PS/2 line conditioner: 2-flop synchronizer followed by a glitch filter that only
// changes its output after FILTER_LEN consecutive samples at the new level.
module ps2_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic clock,
   input  logic reset_n,
   input  logic line_i,
   output logic line_o
);

   localparam int CNT_W = $clog2(FILTER_LEN) + 1;

   logic             sync1_q;
   logic             sync2_q;
   logic             level_q, level_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end
   end

   // Idle PS/2 lines float high, so everything resets to 1.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         sync1_q <= 1'b1;
         sync2_q <= 1'b1;
         level_q <= 1'b1;
         cnt_q   <= '0;
      end else begin
         sync1_q <= line_i;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
      end
   end

   assign line_o = level_q;

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 command transmitter driving PS2_CLK/PS2_DAT open-drain.
// Define PS2_HOST_TX_ACK_CHECK_EN to turn a missing device ACK into tx_error.
module ps2_host_tx
   import ps2_pkg::*;
#(
   parameter int INHIBIT_CYCLES = 6000,
   parameter int TIMEOUT_CYCLES = 1000000,
   parameter int FILTER_LEN     = 8
) (
   input  logic       clock,
   input  logic       reset_n,
   input  logic [7:0] tx_data,
   input  logic       tx_start,
   output logic       tx_busy,
   output logic       tx_done,
   output logic       tx_error,
   input  logic       ps2_clk_i,
   input  logic       ps2_dat_i,
   output logic       ps2_clk_oe,
   output logic       ps2_dat_oe
);

`ifdef PS2_HOST_TX_ACK_CHECK_EN
   localparam logic ACK_CHECK = 1'b1;
`else
   localparam logic ACK_CHECK = 1'b0;
`endif

   localparam int CNT_MAX = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES : TIMEOUT_CYCLES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INH_LAST = CNT_W'(INHIBIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic             clk_f, dat_f;
   logic             clk_prev_q;
   logic             clk_fall;
   logic             tmo_hit;

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [3:0]       bitn_q, bitn_d;
   logic [7:0]       shift_q, shift_d;
   logic             par_q, par_d;
   logic             nack_q, nack_d;
   logic             clk_oe_q, clk_oe_d;
   logic             dat_oe_q, dat_oe_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             err_q, err_d;

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
      .clock   (clock),
      .reset_n (reset_n),
      .line_i  (ps2_clk_i),
      .line_o  (clk_f)
   );

   ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_dat_filter (
      .clock   (clock),
      .reset_n (reset_n),
      .line_i  (ps2_dat_i),
      .line_o  (dat_f)
   );

   assign clk_fall = clk_prev_q & ~clk_f;

   // A device edge in the expiry cycle wins; a line already idle in WAIT_IDLE completes normally.
   assign tmo_hit = (cnt_q == TMO_LAST) && !clk_fall &&
                    ((state_q == ST_SEND) || ((state_q == ST_WAIT_IDLE) && !(clk_f && dat_f)));

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      bitn_d   = bitn_q;
      shift_d  = shift_q;
      par_d    = par_q;
      nack_d   = nack_q;
      clk_oe_d = clk_oe_q;
      dat_oe_d = dat_oe_q;
      busy_d   = busy_q;
      done_d   = 1'b0;
      err_d    = 1'b0;

      case (state_q)
         ST_IDLE: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = '0;
            bitn_d   = '0;
            if (tx_start) begin
               shift_d  = tx_data;
               par_d    = ps2_odd_parity(tx_data);
               nack_d   = 1'b0;
               busy_d   = 1'b1;
               clk_oe_d = 1'b1;
               state_d  = ST_INHIBIT;
            end
         end
         ST_INHIBIT: begin
            if (cnt_q == INH_LAST) begin
               cnt_d    = '0;
               dat_oe_d = 1'b1;
               state_d  = ST_REQ;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_REQ: begin
            clk_oe_d = 1'b0;
            cnt_d    = '0;
            bitn_d   = '0;
            state_d  = ST_SEND;
         end
         ST_SEND: begin
            if (clk_fall) begin
               cnt_d  = '0;
               bitn_d = bitn_q + 4'd1;
               if (!bitn_q[3]) begin
                  dat_oe_d = ~shift_q[bitn_q[2:0]];
               end else if (bitn_q == 4'd8) begin
                  dat_oe_d = ~par_q;
               end else if (bitn_q == 4'd9) begin
                  dat_oe_d = 1'b0;
               end else begin
                  nack_d  = ACK_CHECK & dat_f;
                  state_d = ST_WAIT_IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_WAIT_IDLE: begin
            if (clk_f && dat_f) begin
               busy_d  = 1'b0;
               done_d  = ~nack_q;
               err_d   = nack_q;
               cnt_d   = '0;
               state_d = ST_IDLE;
            end else if (clk_fall) begin
               cnt_d = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         default: begin
            clk_oe_d = 1'b0;
            dat_oe_d = 1'b0;
            busy_d   = 1'b0;
            cnt_d    = '0;
            state_d  = ST_IDLE;
         end
      endcase

      if (tmo_hit) begin
         clk_oe_d = 1'b0;
         dat_oe_d = 1'b0;
         busy_d   = 1'b0;
         done_d   = 1'b0;
         err_d    = 1'b1;
         cnt_d    = '0;
         state_d  = ST_IDLE;
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         bitn_q     <= '0;
         shift_q    <= '0;
         par_q      <= 1'b0;
         nack_q     <= 1'b0;
         clk_oe_q   <= 1'b0;
         dat_oe_q   <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         err_q      <= 1'b0;
         clk_prev_q <= 1'b1;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         bitn_q     <= bitn_d;
         shift_q    <= shift_d;
         par_q      <= par_d;
         nack_q     <= nack_d;
         clk_oe_q   <= clk_oe_d;
         dat_oe_q   <= dat_oe_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_q      <= err_d;
         clk_prev_q <= clk_f;
      end
   end

   assign tx_busy    = busy_q;
   assign tx_done    = done_q;
   assign tx_error   = err_q;
   assign ps2_clk_oe = clk_oe_q;
   assign ps2_dat_oe = dat_oe_q;

endmodule

// File: tb/tb_ps2_host_tx.sv
// Randomized bench for ps2_host_tx with a PS/2 device model and a scoreboard of
// expected frames and completion status.
module tb_ps2_host_tx;
   import ps2_pkg::*;

   localparam int INH     = 50;
   localparam int TMO     = 600;
   localparam int FL      = 8;
   localparam int HALF    = 30;
   localparam int RTS_DLY = 40;

   localparam int M_ACK    = 0;
   localparam int M_NACK   = 1;
   localparam int M_SILENT = 2;
   localparam int M_GLITCH = 3;

   logic       clock;
   logic       reset_n;
   logic [7:0] tx_data;
   logic       tx_start;
   logic       tx_busy, tx_done, tx_error;
   logic       ps2_clk_i, ps2_dat_i;
   logic       ps2_clk_oe, ps2_dat_oe;

   logic        dev_clk;
   logic        dev_pull;
   int          dev_mode;
   logic [10:0] cap;

   typedef struct {
      logic [10:0] frame;
      logic        err;
      logic        has_frame;
   } exp_t;

   exp_t sb_q[$];
   exp_t mon_e;
   int   errors;
   int   checks;

   // Open-drain wiring: either side may pull a line low.
   assign ps2_clk_i = ~ps2_clk_oe & dev_clk;
   assign ps2_dat_i = ~ps2_dat_oe & ~dev_pull;

   ps2_host_tx #(
      .INHIBIT_CYCLES (INH),
      .TIMEOUT_CYCLES (TMO),
      .FILTER_LEN     (FL)
   ) dut (
      .clock      (clock),
      .reset_n    (reset_n),
      .tx_data    (tx_data),
      .tx_start   (tx_start),
      .tx_busy    (tx_busy),
      .tx_done    (tx_done),
      .tx_error   (tx_error),
      .ps2_clk_i  (ps2_clk_i),
      .ps2_dat_i  (ps2_dat_i),
      .ps2_clk_oe (ps2_clk_oe),
      .ps2_dat_oe (ps2_dat_oe)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
      checks++;
      if (act !== exp_v) begin
         errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp_v);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clock);
      #1;
   endtask

   // Line order: start 0, d0..d7, odd parity, stop 1.
   function automatic logic [10:0] model_frame(input logic [7:0] d);
      logic [10:0] f;
      int          ones;
      int          v;
      f    = '0;
      ones = 0;
      v    = int'(d);
      for (int i = 0; i < 8; i++) begin
         f[i+1] = ((v >> i) & 1) == 1;
         ones  += (v >> i) & 1;
      end
      f[9]  = (ones % 2) == 0;
      f[10] = 1'b1;
      return f;
   endfunction

   function automatic logic model_err(input int mode);
      if (mode == M_SILENT) return 1'b1;
`ifdef PS2_HOST_TX_ACK_CHECK_EN
      if (mode == M_NACK) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // Device: waits for request-to-send, clocks 11 bits, samples on rising edges, ACKs.
   initial begin
      dev_clk  = 1'b1;
      dev_pull = 1'b0;
      cap      = '0;
      forever begin
         @(negedge clock);
         if (reset_n && ps2_clk_i && !ps2_dat_i) begin
            if (dev_mode == M_SILENT) begin
               while (!ps2_dat_i) @(negedge clock);
            end else begin
               tick(RTS_DLY);
               cap[0] = ps2_dat_i;
               for (int i = 1; i <= 11; i++) begin
                  if (dev_mode == M_GLITCH && i == 5) begin
                     tick(10);
                     dev_clk = 1'b0;
                     tick(3);
                     dev_clk = 1'b1;
                     tick(HALF - 13);
                  end else begin
                     tick(HALF);
                  end
                  dev_clk = 1'b0;
                  tick(HALF);
                  dev_clk = 1'b1;
                  @(negedge clock);
                  if (i <= 10) cap[i] = ps2_dat_i;
                  if (i == 10 && dev_mode != M_NACK) dev_pull = 1'b1;
                  if (i == 11) dev_pull = 1'b0;
               end
            end
         end
      end
   end

   // Monitor: every status pulse consumes one scoreboard entry.
   initial begin
      forever begin
         @(negedge clock);
         if (tx_done === 1'b1 || tx_error === 1'b1) begin
            check("status_exclusive", 32'(tx_done & tx_error), 32'd0);
            check("busy_low_on_status", 32'(tx_busy), 32'd0);
            if (sb_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_status: done=%0b error=%0b, expected no status", tx_done, tx_error);
            end else begin
               mon_e = sb_q.pop_front();
               check("outcome_error", 32'(tx_error), 32'(mon_e.err));
               check("outcome_done", 32'(tx_done), 32'(!mon_e.err));
               if (mon_e.has_frame) check("frame_bits", 32'(cap), 32'(mon_e.frame));
            end
         end
      end
   end

   task automatic start_tx(input logic [7:0] d, input int mode, input logic expect_status);
      exp_t e;
      dev_mode = mode;
      if (expect_status) begin
         e.frame     = model_frame(d);
         e.err       = model_err(mode);
         e.has_frame = (mode != M_SILENT);
         sb_q.push_back(e);
      end
      @(posedge clock);
      #1;
      tx_data  = d;
      tx_start = 1'b1;
      tick(1);
      tx_start = 1'b0;
   endtask

   task automatic wait_drain(input int limit);
      int n;
      n = 0;
      while (sb_q.size() != 0 && n < limit) begin
         @(negedge clock);
         n++;
      end
      if (sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain_timeout: %0d status pulses outstanding, expected 0", sb_q.size());
         sb_q.delete();
      end
   endtask

   task automatic watch_timing();
      int n;
      int drops;
      @(negedge clock);
      check("busy_after_start", 32'(tx_busy), 32'd1);
      check("clk_oe_after_start", 32'(ps2_clk_oe), 32'd1);
      n = 0;
      while (ps2_clk_oe && !ps2_dat_oe && n < 4 * INH) begin
         n++;
         @(negedge clock);
      end
      check("inhibit_cycles", n, INH);
      check("req_clk_oe", 32'(ps2_clk_oe), 32'd1);
      check("req_dat_oe", 32'(ps2_dat_oe), 32'd1);
      @(negedge clock);
      check("send_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("send_dat_oe", 32'(ps2_dat_oe), 32'd1);
      drops = 0;
      n     = 0;
      while (!(tx_done || tx_error) && n < 20000) begin
         if (!tx_busy) drops++;
         n++;
         @(negedge clock);
      end
      check("busy_whole_frame", drops, 0);
      check("frame_end_seen", 32'(n < 20000), 32'd1);
   endtask

   initial begin
      int         n;
      int         r;
      int         m;
      logic [7:0] d;
      errors   = 0;
      checks   = 0;
      reset_n  = 1'b0;
      tx_start = 1'b0;
      tx_data  = '0;
      dev_mode = M_ACK;

      repeat (3) @(negedge clock);
      check("rst_busy", 32'(tx_busy), 32'd0);
      check("rst_done", 32'(tx_done), 32'd0);
      check("rst_error", 32'(tx_error), 32'd0);
      check("rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      @(posedge clock);
      #1;
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("idle_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("idle_dat_oe", 32'(ps2_dat_oe), 32'd0);

      start_tx(PS2_CMD_LED, M_ACK, 1'b1);
      watch_timing();
      wait_drain(3000);

      // Started the cycle after tx_done.
      start_tx(PS2_CMD_ENABLE, M_ACK, 1'b1);
      watch_timing();
      wait_drain(3000);

      start_tx(PS2_CMD_LED, M_ACK, 1'b1);
      tick(INH + 100);
      tx_data  = 8'h00;
      tx_start = 1'b1;
      tick(1);
      tx_start = 1'b0;
      wait_drain(3000);

      start_tx(8'h5A, M_SILENT, 1'b1);
      n = 0;
      @(negedge clock);
      while (!(ps2_clk_oe && ps2_dat_oe) && n < 4 * INH) begin
         n++;
         @(negedge clock);
      end
      n = 0;
      while (!tx_error && n < TMO + 100) begin
         @(negedge clock);
         n++;
      end
      check("timeout_latency", n, TMO + 1);
      check("timeout_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("timeout_dat_oe", 32'(ps2_dat_oe), 32'd0);
      wait_drain(10);

      start_tx(PS2_CMD_RESET, M_ACK, 1'b1);
      wait_drain(3000);
      start_tx(PS2_ACK_BYTE, M_NACK, 1'b1);
      wait_drain(3000);
      start_tx(PS2_CMD_LED, M_GLITCH, 1'b1);
      wait_drain(3000);

      for (int k = 0; k < 6; k++) begin
         d = 8'($urandom_range(0, 255));
         r = int'($urandom_range(0, 2));
         m = (r == 0) ? M_ACK : ((r == 1) ? M_NACK : M_GLITCH);
         start_tx(d, m, 1'b1);
         wait_drain(3000);
      end

      start_tx(8'h3C, M_SILENT, 1'b0);
      n = 0;
      while (!(!ps2_clk_oe && ps2_dat_oe) && n < 4 * INH) begin
         @(negedge clock);
         n++;
      end
      check("reached_send", 32'(ps2_dat_oe), 32'd1);
      tick(20);
      @(negedge clock);
      reset_n = 1'b0;
      #1;
      check("async_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("async_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      tick(3);
      reset_n = 1'b1;
      repeat (2) @(negedge clock);
      check("post_rst_busy", 32'(tx_busy), 32'd0);
      check("post_rst_clk_oe", 32'(ps2_clk_oe), 32'd0);
      check("post_rst_dat_oe", 32'(ps2_dat_oe), 32'd0);
      check("post_rst_status", 32'(tx_done | tx_error), 32'd0);

      start_tx(PS2_CMD_ENABLE, M_ACK, 1'b1);
      wait_drain(3000);
      repeat (5) @(negedge clock);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #600000;
      $display("FAIL watchdog: simulation time limit reached, expected completion");
      $fatal(1, "watchdog");
   end

endmodule
